// File: rtl/prng_pkg.sv
// Shared types and defaults for the PRNG seed path.
package prng_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned W_DEF      = 32;
  localparam int unsigned HOLD_W_DEF = 16;
  localparam int unsigned CNT_W      = 16;
  // Words the clk2 generator produces per seed; the hold-off exists to let it drain.
  localparam int unsigned PRNG_BATCH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/prng_seed_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found            = 1'b1;
        gnt[IW'(idx)]    = 1'b1;
        gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/prng_seed_scheduler.sv
// clk1 seed scheduler: round-robin grant of seed requesters onto a valid/done
// handshake, with a programmable hold-off after every completed transfer.
module prng_seed_scheduler
  import prng_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned W      = W_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 cfg_en,
  input  logic [HOLD_W-1:0]    cfg_holdoff,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*W-1:0]   req_seed,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 hs_valid,
  output logic [W-1:0]         hs_data,
  input  logic                 hs_done_src,
  output logic                 busy,
  output logic [IW-1:0]        last_id,
  output logic [CNT_W-1:0]     seed_cnt
);

  state_e              state, state_nxt;
  logic [IW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic                hs_valid_nxt;
  logic [W-1:0]        hs_data_nxt;
  logic [IW-1:0]       last_id_nxt;
  logic [CNT_W-1:0]    seed_cnt_nxt;

  logic [N_REQ-1:0]    gnt;
  logic [IW-1:0]       gnt_idx;
  logic                any_req;
  logic [W-1:0]        seed_arr [N_REQ];
  logic                grant_c;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) seed_arr[i] = req_seed[i*W +: W];
  end

  assign grant_c   = (state == IDLE) && cfg_en && any_req;
  assign req_ready = grant_c ? gnt : '0;

  // State and registered outputs
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      hs_valid <= 1'b0;
      hs_data  <= '0;
      busy     <= 1'b0;
      last_id  <= '0;
      seed_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      hs_valid <= hs_valid_nxt;
      hs_data  <= hs_data_nxt;
      busy     <= (state_nxt != IDLE);
      last_id  <= last_id_nxt;
      seed_cnt <= seed_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    hold_cnt_nxt = hold_cnt;
    hs_valid_nxt = hs_valid;
    hs_data_nxt  = hs_data;
    last_id_nxt  = last_id;
    seed_cnt_nxt = seed_cnt;
    unique case (state)
      IDLE: begin
        if (grant_c) begin
          hs_data_nxt  = seed_arr[gnt_idx];
          hs_valid_nxt = 1'b1;
          last_id_nxt  = gnt_idx;
          rr_ptr_nxt   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (hs_done_src) begin
          hs_valid_nxt = 1'b0;
          seed_cnt_nxt = seed_cnt + CNT_W'(1);
          hold_cnt_nxt = cfg_holdoff;
          state_nxt    = (cfg_holdoff != '0) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        if (hold_cnt == HOLD_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prng_seed_scheduler.sv
// Directed bench for prng_seed_scheduler with hand-computed expectations.
module tb_prng_seed_scheduler;

  logic         clk1 = 1'b0;
  logic         rst_n;
  logic         cfg_en;
  logic [15:0]  cfg_holdoff;
  logic [3:0]   req_valid;
  logic [127:0] req_seed;
  logic [3:0]   req_ready;
  logic         hs_valid;
  logic [31:0]  hs_data;
  logic         hs_done_src;
  logic         busy;
  logic [1:0]   last_id;
  logic [15:0]  seed_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk1 = ~clk1;

  prng_seed_scheduler dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_holdoff (cfg_holdoff),
    .req_valid   (req_valid),
    .req_seed    (req_seed),
    .req_ready   (req_ready),
    .hs_valid    (hs_valid),
    .hs_data     (hs_data),
    .hs_done_src (hs_done_src),
    .busy        (busy),
    .last_id     (last_id),
    .seed_cnt    (seed_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};

    cfg_en      = 1'b0;
    cfg_holdoff = 16'd0;
    req_valid   = 4'b0000;
    req_seed    = '0;
    hs_done_src = 1'b0;
    do_reset();

    // Reset state
    chk("rst_hs_valid", 32'(hs_valid), 32'd0);
    chk("rst_hs_data",  hs_data,       32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_last_id",  32'(last_id),  32'd0);
    chk("rst_seed_cnt", 32'(seed_cnt), 32'd0);
    chk("rst_ready",    32'(req_ready), 32'd0);

    // 1: single requester, done three cycles after hs_valid
    cfg_en    = 1'b1;
    req_valid = 4'b0001;
    req_seed  = {32'h0, 32'h0, 32'h0, 32'h12345678};
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t1_hs_valid", 32'(hs_valid), 32'd1);
    chk("t1_ready_send", 32'(req_ready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    chk("t1_data_c1", hs_data, 32'h12345678);
    tick();
    chk("t1_data_c2", hs_data, 32'h12345678);
    tick();
    chk("t1_data_c3", hs_data, 32'h12345678);
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    chk("t1_hs_valid_done", 32'(hs_valid), 32'd0);
    chk("t1_seed_cnt", 32'(seed_cnt), 32'd1);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // 2: all requesters held, rotation from a fresh pointer
    do_reset();
    cfg_en    = 1'b1;
    req_valid = 4'b1111;
    req_seed  = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    for (int g = 0; g < 5; g++) begin
      #1;
      chk($sformatf("t2_ready_%0d", g), 32'(req_ready), 32'(1) << exp_order[g]);
      tick();
      chk($sformatf("t2_last_id_%0d", g), 32'(last_id), 32'(exp_order[g]));
      chk($sformatf("t2_data_%0d", g), hs_data, 32'hA0000000 + 32'(exp_order[g]));
      hs_done_src = 1'b1;
      tick();
      hs_done_src = 1'b0;
      chk($sformatf("t2_hs_valid_%0d", g), 32'(hs_valid), 32'd0);
    end
    chk("t2_seed_cnt", 32'(seed_cnt), 32'd5);

    // 3: holdoff=5, busy exactly 5 cycles, next hs_valid 6 cycles after done
    cfg_holdoff = 16'd5;
    req_valid   = 4'b0100;
    #1;
    chk("t3_ready", 32'(req_ready), 32'h4);
    tick();
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    chk("t3_seed_cnt", 32'(seed_cnt), 32'd6);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_busy_%0d", i), 32'(busy), 32'd1);
      chk($sformatf("t3_ready_hold_%0d", i), 32'(req_ready), 32'd0);
      tick();
    end
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_hs_valid_pre", 32'(hs_valid), 32'd0);
    chk("t3_ready_again", 32'(req_ready), 32'h4);
    tick();
    chk("t3_hs_valid_rise", 32'(hs_valid), 32'd1);
    chk("t3_last_id", 32'(last_id), 32'd2);

    // 4: done pulses in HOLD and IDLE are ignored
    req_valid   = 4'b0000;
    cfg_holdoff = 16'd3;
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    chk("t4_cnt_hold", 32'(seed_cnt), 32'd7);
    chk("t4_busy_hold", 32'(busy), 32'd1);
    tick();
    chk("t4_busy_hold2", 32'(busy), 32'd1);
    tick();
    chk("t4_busy_idle", 32'(busy), 32'd0);
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    chk("t4_cnt_idle", 32'(seed_cnt), 32'd7);
    chk("t4_busy_idle2", 32'(busy), 32'd0);
    chk("t4_hs_valid_idle", 32'(hs_valid), 32'd0);

    // 5: cfg_en dropped mid-handshake completes, then no further grants
    cfg_holdoff = 16'd0;
    req_valid   = 4'b1111;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h8);
    tick();
    cfg_en = 1'b0;
    chk("t5_last_id", 32'(last_id), 32'd3);
    tick();
    chk("t5_hs_valid_held", 32'(hs_valid), 32'd1);
    hs_done_src = 1'b1;
    tick();
    hs_done_src = 1'b0;
    chk("t5_seed_cnt", 32'(seed_cnt), 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_no_grant_%0d", i), 32'(req_ready), 32'd0);
      chk($sformatf("t5_hs_idle_%0d", i), 32'(hs_valid), 32'd0);
      tick();
    end

    // 6: reset during SEND clears outputs at once; pointer restarts at 0
    cfg_en    = 1'b1;
    req_valid = 4'b0010;
    req_seed  = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    #1;
    chk("t6_ready", 32'(req_ready), 32'h2);
    tick();
    chk("t6_data", hs_data, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hs_valid", 32'(hs_valid), 32'd0);
    chk("t6_rst_hs_data",  hs_data,       32'd0);
    chk("t6_rst_seed_cnt", 32'(seed_cnt), 32'd0);
    chk("t6_rst_busy",     32'(busy),     32'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t6_post_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t6_post_last_id", 32'(last_id), 32'd0);
    chk("t6_post_data", hs_data, 32'h11111111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
